// File: rtl/refresh_scheduler.sv
// Refresh initiator for an array of MEM_WRAPPER banks: slot-paced requests, round-robin bank walk,
// one-cycle SR start, partner enable, done/timeout handshake and sticky overrun/timeout flags.

module refresh_scheduler_lane #(
   parameter int NUM_BANKS = 4,
   parameter int BANK_W    = 2,
   parameter int IDX       = 0
) (
   input  logic [BANK_W-1:0] ref_bank,
   input  logic              in_start,
   input  logic              in_ref,
   output logic              start_sr,
   output logic              ref_en_current,
   output logic              ref_en_old
);
   localparam logic [BANK_W-1:0] SELF = BANK_W'(IDX);
   // This bank is the partner when the target is the bank after it.
   localparam logic [BANK_W-1:0] NEXT = BANK_W'((IDX + 1) % NUM_BANKS);

   assign start_sr       = in_start && (ref_bank == SELF);
   assign ref_en_current = in_ref   && (ref_bank == SELF);
   assign ref_en_old     = in_ref   && (ref_bank == NEXT);
endmodule

module refresh_scheduler #(
   parameter  int NUM_BANKS   = 4,
   parameter  int SLOT_CYCLES = 256,
   parameter  int TIMEOUT     = 200,
   localparam int BANK_W      = $clog2(NUM_BANKS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 err_clr,
   input  logic [NUM_BANKS-1:0] ref_done,
   output logic [NUM_BANKS-1:0] start_sr,
   output logic [NUM_BANKS-1:0] ref_en_current,
   output logic [NUM_BANKS-1:0] ref_en_old,
   output logic [BANK_W-1:0]    ref_bank,
   output logic                 busy,
   output logic [15:0]          ref_count,
   output logic                 overrun_err,
   output logic                 timeout_err
);
   localparam int TMR_W = $clog2(SLOT_CYCLES);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RELEASE} state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] cnt;
   logic             pending;
   logic             in_start, in_ref;
   logic             wrap, done_hit, tmo_hit;

   assign wrap     = enable && (timer == TMR_W'(SLOT_CYCLES - 1));
   assign done_hit = ref_done[ref_bank];
   assign tmo_hit  = (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (pending && enable) state_nxt = START;
         START:     state_nxt = WAIT_DONE;
         WAIT_DONE: if (done_hit || tmo_hit) state_nxt = RELEASE;
         RELEASE:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_start = 1'b0;
      in_ref   = 1'b0;
      busy     = 1'b0;
      case (state)
         START:     begin in_start = 1'b1; in_ref = 1'b1; busy = 1'b1; end
         WAIT_DONE: begin in_ref = 1'b1; busy = 1'b1; end
         RELEASE:   busy = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer       <= '0;
         pending     <= 1'b0;
         cnt         <= '0;
         ref_bank    <= '0;
         ref_count   <= '0;
         overrun_err <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (!enable || wrap) timer <= '0;
         else                 timer <= timer + 1'b1;

         // A new wrap re-arms the request even if it coincides with the start taking the old one.
         if (wrap)                                  pending <= 1'b1;
         else if (state == IDLE && enable && pending) pending <= 1'b0;

         if (wrap && (pending || state != IDLE)) overrun_err <= 1'b1;
         else if (err_clr)                       overrun_err <= 1'b0;

         if (state == WAIT_DONE && !done_hit && tmo_hit) timeout_err <= 1'b1;
         else if (err_clr)                                timeout_err <= 1'b0;

         if (state == START)          cnt <= '0;
         else if (state == WAIT_DONE) cnt <= cnt + 1'b1;

         if (state == WAIT_DONE && done_hit) ref_count <= ref_count + 16'd1;

         if (state == RELEASE)
            ref_bank <= (ref_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : ref_bank + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
      refresh_scheduler_lane #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W), .IDX(i)) u_lane (
         .ref_bank       (ref_bank),
         .in_start       (in_start),
         .in_ref         (in_ref),
         .start_sr       (start_sr[i]),
         .ref_en_current (ref_en_current[i]),
         .ref_en_old     (ref_en_old[i])
      );
   end
endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench: main instance (4 banks, 256-cycle slot, 200 timeout) plus a short-slot,
// long-timeout instance used to provoke overruns.

module tb_refresh_scheduler;
   logic       clk = 1'b0;
   logic       rst, enable, err_clr, ovr_clr;
   logic [3:0] ref_done, ovr_done;
   logic [3:0] start_sr, ref_en_current, ref_en_old;
   logic [1:0] ref_bank;
   logic       busy, overrun_err, timeout_err;
   logic [15:0] ref_count;
   logic [3:0] o_start, o_cur, o_old;
   logic [1:0] o_bank;
   logic       o_busy, o_overrun, o_timeout;
   logic [15:0] o_count;
   int         cyc, nchk, npass, starts;
   logic [3:0] exp_oh, exp_old;

   always #5 clk = ~clk;

   refresh_scheduler #(.NUM_BANKS(4), .SLOT_CYCLES(256), .TIMEOUT(200)) dut (
      .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr), .ref_done(ref_done),
      .start_sr(start_sr), .ref_en_current(ref_en_current), .ref_en_old(ref_en_old),
      .ref_bank(ref_bank), .busy(busy), .ref_count(ref_count),
      .overrun_err(overrun_err), .timeout_err(timeout_err));

   refresh_scheduler #(.NUM_BANKS(4), .SLOT_CYCLES(16), .TIMEOUT(64)) u_ovr (
      .clk(clk), .rst(rst), .enable(enable), .err_clr(ovr_clr), .ref_done(ovr_done),
      .start_sr(o_start), .ref_en_current(o_cur), .ref_en_old(o_old),
      .ref_bank(o_bank), .busy(o_busy), .ref_count(o_count),
      .overrun_err(o_overrun), .timeout_err(o_timeout));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Advance to 1ns after posedge number n (counted from reset release).
   task automatic go(input int n);
      while (cyc < n) begin
         @(posedge clk);
         cyc++;
         #1;
      end
   endtask

   initial begin
      nchk = 0; npass = 0; cyc = 0;
      enable = 0; err_clr = 0; ovr_clr = 0; ref_done = 0; ovr_done = 0;
      rst = 1; #1 rst = 0; #1;
      check("rst_start", start_sr, 4'h0);
      check("rst_cur", ref_en_current, 4'h0);
      check("rst_old", ref_en_old, 4'h0);
      check("rst_bank", ref_bank, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_count", ref_count, 16'd0);
      check("rst_ovr", overrun_err, 1'b0);
      check("rst_tmo", timeout_err, 1'b0);
      rst = 1; enable = 1;

      // Short-slot instance: refresh never completes, wraps while busy.
      go(17);  check("o_start", o_start, 4'b0001);
      go(31);  check("o_ovr_pre", o_overrun, 1'b0);
      go(32);  check("o_ovr_set", o_overrun, 1'b1);
      go(82);  check("o_tmo", o_timeout, 1'b1);
      go(95);  ovr_clr = 1;
      go(96);  check("o_clr_set_wins", o_overrun, 1'b1);
      go(97);  check("o_clr", o_overrun, 1'b0);
      check("o_clr_tmo", o_timeout, 1'b0);
      ovr_clr = 0;

      // First request: pending at 256, start at 257.
      go(256); check("lat_nostart", start_sr, 4'h0);
      go(257); check("start0", start_sr, 4'b0001);
      check("cur0", ref_en_current, 4'b0001);
      check("old0", ref_en_old, 4'b1000);
      check("busy0", busy, 1'b1);
      go(258); check("pulse1cyc", start_sr, 4'h0);
      check("cur0_hold", ref_en_current, 4'b0001);
      go(267); check("cur0_wait", ref_en_current, 4'b0001);
      ref_done = 4'b0001;
      go(268); check("cur0_drop", ref_en_current, 4'h0);
      check("old0_drop", ref_en_old, 4'h0);
      check("count1", ref_count, 16'd1);
      ref_done = 0;
      go(269); check("bank1", ref_bank, 2'd1);
      check("idle1", busy, 1'b0);

      // Four more slots with prompt done; done raised during START must be ignored.
      for (int k = 1; k <= 4; k++) begin
         int s, b;
         s = 257 + 256 * k;
         b = k % 4;
         exp_oh  = 4'(1 << b);
         exp_old = 4'(1 << ((b + 3) % 4));
         go(s);   check("rr_start", start_sr, exp_oh);
         check("rr_old", ref_en_old, exp_old);
         ref_done = exp_oh;
         go(s + 1); check("rr_ign_start", ref_en_current, exp_oh);
         check("rr_pulse", start_sr, 4'h0);
         go(s + 2); check("rr_drop", ref_en_current, 4'h0);
         check("rr_count", ref_count, 32'(k + 1));
         ref_done = 0;
         go(s + 3); check("rr_bank", ref_bank, 32'((b + 1) % 4));
      end

      // Timeout on bank 1; another bank's done must not count.
      go(1537); check("to_start", start_sr, 4'b0010);
      ref_done = 4'b0001;
      go(1737); check("to_pre", timeout_err, 1'b0);
      check("to_cur", ref_en_current, 4'b0010);
      go(1738); check("to_set", timeout_err, 1'b1);
      check("to_drop", ref_en_current, 4'h0);
      check("to_count", ref_count, 16'd5);
      go(1739); check("to_bank", ref_bank, 2'd2);
      err_clr = 1;
      go(1740); check("to_clr", timeout_err, 1'b0);
      err_clr = 0; ref_done = 0;

      // Async reset mid WAIT_DONE.
      go(1793); check("b2_start", start_sr, 4'b0100);
      check("b2_old", ref_en_old, 4'b0010);
      go(1800); check("b2_busy", busy, 1'b1);
      #2 rst = 0; #1;
      check("ar_busy", busy, 1'b0);
      check("ar_cur", ref_en_current, 4'h0);
      check("ar_old", ref_en_old, 4'h0);
      check("ar_bank", ref_bank, 2'd0);
      check("ar_count", ref_count, 16'd0);
      #2 rst = 1; cyc = 0;

      // Restart from bank 0, then drop enable mid refresh.
      go(257); check("rs_start", start_sr, 4'b0001);
      check("rs_bank", ref_bank, 2'd0);
      go(262); enable = 0;
      go(267); check("en0_cur", ref_en_current, 4'b0001);
      ref_done = 4'b0001;
      go(268); check("en0_drop", ref_en_current, 4'h0);
      check("en0_count", ref_count, 16'd1);
      ref_done = 0;
      starts = 0;
      for (int i = 0; i < 600; i++) begin
         go(cyc + 1);
         if (start_sr != 4'h0) starts++;
      end
      check("en0_nostart", starts, 0);
      check("en0_idle", busy, 1'b0);
      check("en0_bank", ref_bank, 2'd1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
